// File: rtl/sensor_poll_sched_pkg.sv
// Shared types and constants for the two-channel sensor polling scheduler.
// Holds the FSM states, channel ids, ASCII query bytes and default timing.
package sensor_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        SEND,
        WAIT_TX,
        LISTEN,
        NEXT
    } poll_state_t;

    localparam logic CH_HR   = 1'b0;
    localparam logic CH_DIST = 1'b1;

    // "HR?" for the heart-rate sensor, "DS?" for the distance sensor
    localparam logic [7:0] CMD [2][3] = '{'{8'h48, 8'h52, 8'h3F},
                                          '{8'h44, 8'h53, 8'h3F}};

    localparam int DEF_POLL_CYCLES    = 2500000;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_MAX_RETRY      = 2;

    function automatic logic [7:0] cmd_byte(input logic ch, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD[ch][0];
            2'd1:    b = CMD[ch][1];
            default: b = CMD[ch][2];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sensor_poll_sched_if.sv
// UART and parser handshake bundle between the scheduler (master) and the
// uart_tx / packet-parser side (slave).
interface sensor_poll_sched_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_gate;
    logic       rx_sel;
    logic       done_hr;
    logic       done_dist;

    modport master (
        output tx_en, tx_data, rx_gate, rx_sel,
        input  tx_busy, done_hr, done_dist
    );

    modport slave (
        input  tx_en, tx_data, rx_gate, rx_sel,
        output tx_busy, done_hr, done_dist
    );
endinterface

// File: rtl/sensor_poll_sched_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
// Saturates at LIMIT-1 so a stalled owner never sees a wrapped count.
module poll_timer #(
    parameter  int LIMIT = 16,
    localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         tc
);
    logic [W-1:0] count;

    assign tc = (count == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (run && !tc)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/sensor_poll_sched.sv
// Shares one UART between the heart-rate and distance sensors: alternately sends
// each channel's 3-byte query, gates RX to its parser, and retries on timeout.
module sensor_poll_sched
    import sensor_poll_pkg::*;
#(
    parameter int POLL_CYCLES    = DEF_POLL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    sensor_poll_sched_if.master        bus,
    output logic                       hr_fault,
    output logic                       dist_fault,
    output logic                       active_ch
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    poll_state_t   state, state_next;
    logic          ch, ch_next;
    logic [1:0]    idx, idx_next;
    logic [RW-1:0] retry, retry_next;
    logic          hr_fault_next, dist_fault_next;
    logic          busy_r, rx_sel_q;
    logic          slot_tc, to_tc;
    logic          tx_fall, done_match;

    assign tx_fall    = busy_r & ~bus.tx_busy;
    assign done_match = (ch == CH_DIST) ? bus.done_dist : bus.done_hr;
    assign bus.rx_sel = rx_sel_q;

    // Both timers are held at zero outside their own state, so every entry starts a fresh count
    poll_timer #(.LIMIT(POLL_CYCLES)) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state != WAIT_SLOT),
        .load     (1'b0),
        .load_val ('0),
        .run      (state == WAIT_SLOT),
        .tc       (slot_tc)
    );

    poll_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state != LISTEN),
        .load     (1'b0),
        .load_val ('0),
        .run      (state == LISTEN),
        .tc       (to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= CH_HR;
            idx        <= '0;
            retry      <= '0;
            busy_r     <= 1'b0;
            rx_sel_q   <= 1'b0;
            hr_fault   <= 1'b0;
            dist_fault <= 1'b0;
            active_ch  <= 1'b0;
        end else begin
            state      <= state_next;
            ch         <= ch_next;
            idx        <= idx_next;
            retry      <= retry_next;
            busy_r     <= bus.tx_busy;
            hr_fault   <= hr_fault_next;
            dist_fault <= dist_fault_next;
            active_ch  <= ch_next;
            if (state == WAIT_TX && state_next == LISTEN)
                rx_sel_q <= ch;
        end
    end

    always_comb begin
        state_next      = state;
        ch_next         = ch;
        idx_next        = idx;
        retry_next      = retry;
        hr_fault_next   = hr_fault;
        dist_fault_next = dist_fault;
        bus.tx_en       = 1'b0;
        bus.tx_data     = 8'h00;
        bus.rx_gate     = 1'b0;

        case (state)
            IDLE: begin
                if (en)
                    state_next = WAIT_SLOT;
            end
            WAIT_SLOT: begin
                if (!en)
                    state_next = IDLE;
                else if (slot_tc) begin
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    bus.tx_en   = 1'b1;
                    bus.tx_data = cmd_byte(ch, idx);
                    state_next  = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_fall) begin
                    if (idx == 2'd2)
                        state_next = LISTEN;
                    else begin
                        idx_next   = idx + 2'd1;
                        state_next = SEND;
                    end
                end
            end
            LISTEN: begin
                bus.rx_gate = 1'b1;
                // A reply landing on the timeout's last cycle still counts as a success
                if (done_match) begin
                    if (ch == CH_HR) hr_fault_next = 1'b0;
                    else             dist_fault_next = 1'b0;
                    retry_next = '0;
                    state_next = NEXT;
                end else if (to_tc) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_next = retry + 1'b1;
                        idx_next   = '0;
                        state_next = SEND;
                    end else begin
                        if (ch == CH_HR) hr_fault_next = 1'b1;
                        else             dist_fault_next = 1'b1;
                        retry_next = '0;
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                ch_next    = ~ch;
                state_next = en ? WAIT_SLOT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
